// File: rtl/irrigation_pkg.sv
// Shared types, message codes and the irrigation duration calculation
// for the irrigation scheduler.
package irrigation_pkg;

  localparam int SENSOR_W = 10;
  localparam int TIME_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_EVAL    = 3'd2,
    ST_WATER   = 3'd3,
    ST_PAUSE   = 3'd4,
    ST_PAUSE_W = 3'd5
  } state_e;

  localparam logic [2:0] MSG_IDLE     = 3'd0;
  localparam logic [2:0] MSG_SENSING  = 3'd1;
  localparam logic [2:0] MSG_WATERING = 3'd2;
  localparam logic [2:0] MSG_RAIN     = 3'd3;
  localparam logic [2:0] MSG_CONFIG   = 3'd4;
  localparam logic [2:0] MSG_DONE     = 3'd5;

  typedef struct packed {
    logic              rain;
    logic [TIME_W-1:0] secs;
  } eval_t;

  // Rain forces zero; otherwise a soil-dependent base plus a hot-weather bonus, saturated to 8 bits.
  function automatic eval_t calc_irrigation(
    input logic [SENSOR_W-1:0] soil,
    input logic [SENSOR_W-1:0] temp,
    input logic [SENSOR_W-1:0] rain,
    input logic [SENSOR_W-1:0] soil_dry,
    input logic [SENSOR_W-1:0] soil_wet,
    input logic [SENSOR_W-1:0] temp_hot,
    input logic [SENSOR_W-1:0] rain_yes,
    input logic [TIME_W-1:0]   dry_s,
    input logic [TIME_W-1:0]   moist_s,
    input logic [TIME_W-1:0]   hot_s
  );
    eval_t         res;
    logic [TIME_W:0] sum;
    res.rain = (rain >= rain_yes);
    if (res.rain) begin
      sum = '0;
    end else if (soil >= soil_dry) begin
      sum = {1'b0, dry_s};
    end else if (soil > soil_wet) begin
      sum = {1'b0, moist_s};
    end else begin
      sum = '0;
    end
    if ((sum != '0) && (temp >= temp_hot)) begin
      sum = sum + {1'b0, hot_s};
    end else begin
      sum = sum;
    end
    res.secs = sum[TIME_W] ? {TIME_W{1'b1}} : sum[TIME_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/irrigation_scheduler_tick.sv
// second_tick_gen: free-running one-cycle tick every TICK_DIV clocks,
// phase-locked to reset release.
module second_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int             CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0]  PRE  = CW'(TICK_DIV - 2);
  localparam logic [CW-1:0]  ONE  = CW'(1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Divider counter; the tick is registered one count early so it lines up with the wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + ONE;
      r_tick <= (r_cnt == PRE);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/irrigation_scheduler.sv
// irrigation_scheduler: sample/evaluate/water sequencer with keypad pause.
// Optional build macro IRRIG_RAIN_ABORT_EN aborts watering when rain appears.
module irrigation_scheduler
  import irrigation_pkg::*;
#(
  parameter int TICK_DIV        = 50_000_000,
  parameter int SETTLE_CYCLES   = 1000,
  parameter int SAMPLE_PERIOD_S = 60,
  parameter int DRY_S           = 30,
  parameter int MOIST_S         = 15,
  parameter int HOT_EXTRA_S     = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SENSOR_W-1:0] soil_digital,
  input  logic [SENSOR_W-1:0] dht11_digital,
  input  logic [SENSOR_W-1:0] rain_digital,
  input  logic [SENSOR_W-1:0] param_soil_dry,
  input  logic [SENSOR_W-1:0] param_soil_wet,
  input  logic [SENSOR_W-1:0] param_temp_hot,
  input  logic [SENSOR_W-1:0] param_rain_yes,
  input  logic                config_busy,
  input  logic                updated,
  output logic                sensor_enable,
  output logic                pump_on,
  output logic                watering_in_progress,
  output logic [TIME_W-1:0]   watering_timer,
  output logic [TIME_W-1:0]   irrigation_time,
  output logic                rain_present,
  output logic [2:0]          lcd_msg_sel
);

  localparam int             IW          = $clog2(SAMPLE_PERIOD_S + 1);
  localparam logic [IW-1:0]  PERIOD      = IW'(SAMPLE_PERIOD_S);
  localparam logic [IW-1:0]  IV_ONE      = IW'(1);
  localparam int             SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0]  ST_ONE      = SW'(1);

  logic              w_tick;
  eval_t             w_eval;
  state_e            r_state,    w_next_state;
  logic [IW-1:0]     r_interval, w_interval_nx;
  logic [SW-1:0]     r_settle,   w_settle_nx;
  logic [TIME_W-1:0] r_timer,    w_timer_nx;
  logic [TIME_W-1:0] r_irrig,    w_irrig_nx;
  logic              r_rain,     w_rain_nx;
  logic              r_done,     w_done_nx;
  logic              r_sensor_enable, w_sensor_enable;
  logic              r_pump_on,       w_pump_on;
  logic              r_in_prog,       w_in_prog;
  logic [2:0]        r_lcd,           w_lcd;

  second_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  assign w_eval = calc_irrigation(soil_digital, dht11_digital, rain_digital,
                                  param_soil_dry, param_soil_wet, param_temp_hot,
                                  param_rain_yes, TIME_W'(DRY_S), TIME_W'(MOIST_S),
                                  TIME_W'(HOT_EXTRA_S));

  // Next-state and next-datapath logic; config_busy outranks ticks and interval expiry.
  always_comb begin
    w_next_state  = r_state;
    w_interval_nx = r_interval;
    w_settle_nx   = r_settle;
    w_timer_nx    = r_timer;
    w_irrig_nx    = r_irrig;
    w_rain_nx     = r_rain;
    w_done_nx     = r_done;
    case (r_state)
      ST_IDLE: begin
        if (config_busy) begin
          w_next_state = ST_PAUSE;
        end else if (updated || (r_interval == PERIOD)) begin
          w_next_state = ST_SETTLE;
        end else if (w_tick) begin
          w_interval_nx = r_interval + IV_ONE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (config_busy) begin
          w_next_state = ST_PAUSE;
        end else if (r_settle == SETTLE_LAST) begin
          w_next_state = ST_EVAL;
        end else begin
          w_settle_nx = r_settle + ST_ONE;
        end
      end
      ST_EVAL: begin
        if (config_busy) begin
          w_next_state = ST_PAUSE;
        end else begin
          w_irrig_nx   = w_eval.secs;
          w_rain_nx    = w_eval.rain;
          w_timer_nx   = w_eval.secs;
          w_next_state = (w_eval.secs != '0) ? ST_WATER : ST_IDLE;
        end
      end
      ST_WATER: begin
`ifdef IRRIG_RAIN_ABORT_EN
        if (w_eval.rain) begin
          w_next_state = ST_IDLE;
          w_timer_nx   = '0;
          w_rain_nx    = 1'b1;
        end else
`endif
        if (config_busy) begin
          w_next_state = ST_PAUSE_W;
        end else if (w_tick) begin
          if (r_timer <= 8'd1) begin
            w_next_state = ST_IDLE;
            w_timer_nx   = '0;
            w_done_nx    = 1'b1;
          end else begin
            w_timer_nx = r_timer - 8'd1;
          end
        end else begin
          w_next_state = ST_WATER;
        end
      end
      ST_PAUSE: begin
        if (!config_busy) begin
          w_next_state = ST_SETTLE;
        end else begin
          w_next_state = ST_PAUSE;
        end
      end
      ST_PAUSE_W: begin
        if (!config_busy) begin
          w_next_state = ST_WATER;
        end else begin
          w_next_state = ST_PAUSE_W;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
    // A fresh sample cycle restarts the interval, the settle count and clears the DONE banner.
    if ((w_next_state == ST_SETTLE) && (r_state != ST_SETTLE)) begin
      w_interval_nx = '0;
      w_settle_nx   = '0;
      w_done_nx     = 1'b0;
    end else begin
      w_done_nx = w_done_nx;
    end
  end

  // Output values are decoded from the upcoming state so they register together with it.
  always_comb begin
    w_sensor_enable = (w_next_state == ST_SETTLE);
    w_pump_on       = (w_next_state == ST_WATER);
    w_in_prog       = (w_next_state == ST_WATER) || (w_next_state == ST_PAUSE_W);
    w_lcd           = MSG_IDLE;
    case (w_next_state)
      ST_IDLE: begin
        if (w_done_nx) begin
          w_lcd = MSG_DONE;
        end else if (w_rain_nx) begin
          w_lcd = MSG_RAIN;
        end else begin
          w_lcd = MSG_IDLE;
        end
      end
      ST_SETTLE, ST_EVAL:   w_lcd = MSG_SENSING;
      ST_WATER:             w_lcd = MSG_WATERING;
      ST_PAUSE, ST_PAUSE_W: w_lcd = MSG_CONFIG;
      default:              w_lcd = MSG_IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_interval      <= '0;
      r_settle        <= '0;
      r_timer         <= '0;
      r_irrig         <= '0;
      r_rain          <= 1'b0;
      r_done          <= 1'b0;
      r_sensor_enable <= 1'b0;
      r_pump_on       <= 1'b0;
      r_in_prog       <= 1'b0;
      r_lcd           <= MSG_IDLE;
    end else begin
      r_state         <= w_next_state;
      r_interval      <= w_interval_nx;
      r_settle        <= w_settle_nx;
      r_timer         <= w_timer_nx;
      r_irrig         <= w_irrig_nx;
      r_rain          <= w_rain_nx;
      r_done          <= w_done_nx;
      r_sensor_enable <= w_sensor_enable;
      r_pump_on       <= w_pump_on;
      r_in_prog       <= w_in_prog;
      r_lcd           <= w_lcd;
    end
  end

  assign sensor_enable        = r_sensor_enable;
  assign pump_on              = r_pump_on;
  assign watering_in_progress = r_in_prog;
  assign watering_timer       = r_timer;
  assign irrigation_time      = r_irrig;
  assign rain_present         = r_rain;
  assign lcd_msg_sel          = r_lcd;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Self-checking bench for irrigation_scheduler: directed scenarios plus
// randomized evaluations against a behavioural duration/timing model.
module tb_irrigation_scheduler;

  localparam int TD    = 4;
  localparam int SC    = 3;
  localparam int SP    = 2;
  localparam int DRY   = 30;
  localparam int MOIST = 15;
  localparam int HOT   = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] soil_digital, dht11_digital, rain_digital;
  logic [9:0] param_soil_dry, param_soil_wet, param_temp_hot, param_rain_yes;
  logic       config_busy, updated;
  logic       sensor_enable, pump_on, watering_in_progress, rain_present;
  logic [7:0] watering_timer, irrigation_time;
  logic [2:0] lcd_msg_sel;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  irrigation_scheduler #(
    .TICK_DIV(TD), .SETTLE_CYCLES(SC), .SAMPLE_PERIOD_S(SP),
    .DRY_S(DRY), .MOIST_S(MOIST), .HOT_EXTRA_S(HOT)
  ) dut (
    .clk(clk), .reset(rst_n),
    .soil_digital(soil_digital), .dht11_digital(dht11_digital), .rain_digital(rain_digital),
    .param_soil_dry(param_soil_dry), .param_soil_wet(param_soil_wet),
    .param_temp_hot(param_temp_hot), .param_rain_yes(param_rain_yes),
    .config_busy(config_busy), .updated(updated),
    .sensor_enable(sensor_enable), .pump_on(pump_on),
    .watering_in_progress(watering_in_progress), .watering_timer(watering_timer),
    .irrigation_time(irrigation_time), .rain_present(rain_present),
    .lcd_msg_sel(lcd_msg_sel)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic int sig_sel(input int sel);
    case (sel)
      0: return int'(sensor_enable);
      1: return int'(pump_on);
      2: return int'(watering_timer);
      default: return -1;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input int val, input int budget);
    int n = 0;
    while ((sig_sel(sel) != val) && (n < budget)) begin
      step();
      n++;
    end
    if (sig_sel(sel) != val) check_val($sformatf("wait_timeout_sel%0d", sel), sig_sel(sel), val);
  endtask

  // Duration rules in plain integer arithmetic.
  function automatic int model_time(input int soil, temp, rain, dry, wet, hot, ry);
    int base;
    if (rain >= ry) return 0;
    if (soil >= dry) base = DRY;
    else if (soil > wet) base = MOIST;
    else base = 0;
    if (base > 0 && temp >= hot) base = base + HOT;
    return (base > 255) ? 255 : base;
  endfunction

  // Ticks land on edges that are multiples of TD after reset release; the t-th one after `start` ends watering.
  function automatic int fall_edge(input int start, input int t);
    return (start / TD + 1) * TD + (t - 1) * TD;
  endfunction

  task automatic run_eval(input int soil, temp, rain, dry, wet, hot, ry,
                          output int t_exp, output int p_edge, output int rise_edge);
    int fall, rexp;
    soil_digital = 10'(soil); dht11_digital = 10'(temp); rain_digital = 10'(rain);
    param_soil_dry = 10'(dry); param_soil_wet = 10'(wet);
    param_temp_hot = 10'(hot); param_rain_yes = 10'(ry);
    wait_sig(0, 1, 60);
    rise_edge = cyc;
    wait_sig(0, 0, 20);
    fall = cyc;
    check_val("settle_len", fall - rise_edge, SC);
    step();
    t_exp = model_time(soil, temp, rain, dry, wet, hot, ry);
    rexp  = (rain >= ry) ? 1 : 0;
    check_val("irrigation_time", irrigation_time, t_exp);
    check_val("rain_present", rain_present, rexp);
    check_val("pump_after_eval", pump_on, (t_exp > 0) ? 1 : 0);
    check_val("wip_after_eval", watering_in_progress, (t_exp > 0) ? 1 : 0);
    check_val("timer_load", watering_timer, t_exp);
    check_val("lcd_after_eval", lcd_msg_sel, (t_exp > 0) ? 2 : (rexp ? 3 : 0));
    p_edge = cyc;
  endtask

  task automatic finish_water(input int t, input int p_edge);
    int guard = 0;
    while (pump_on && guard < (t + 2) * TD) begin
      check_val("timer_track", watering_timer, t - (cyc / TD - p_edge / TD));
      step();
      guard++;
    end
    check_val("pump_fall_edge", cyc, fall_edge(p_edge, t));
    check_val("pump_off", pump_on, 0);
    check_val("lcd_done", lcd_msg_sel, 5);
    check_val("timer_zero", watering_timer, 0);
    check_val("wip_off", watering_in_progress, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t, p, rise;
    soil_digital = 10'd800; dht11_digital = 10'd500; rain_digital = 10'd100;
    param_soil_dry = 10'd700; param_soil_wet = 10'd300;
    param_temp_hot = 10'd400; param_rain_yes = 10'd600;
    config_busy = 1'b0; updated = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_sensor_enable", sensor_enable, 0);
    check_val("rst_pump_on", pump_on, 0);
    check_val("rst_wip", watering_in_progress, 0);
    check_val("rst_timer", watering_timer, 0);
    check_val("rst_irrig", irrigation_time, 0);
    check_val("rst_rain", rain_present, 0);
    check_val("rst_lcd", lcd_msg_sel, 0);
    updated = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;

    // Dry + hot, no rain: 40 seconds, first sensing at cycle 9.
    run_eval(800, 500, 100, 700, 300, 400, 600, t, p, rise);
    check_val("first_sense_cycle", rise, 9);
    finish_water(t, p);

    // Moist soil, cool: base only.
    run_eval(500, 300, 100, 700, 300, 400, 600, t, p, rise);
    finish_water(t, p);

    // Wet soil: no watering; then an update pulse restarts sensing immediately.
    run_eval(200, 300, 100, 700, 300, 400, 600, t, p, rise);
    step();
    check_val("idle_no_pump", pump_on, 0);
    updated = 1'b1;
    step();
    updated = 1'b0;
    check_val("updated_settle", sensor_enable, 1);
    check_val("updated_lcd", lcd_msg_sel, 1);
    wait_sig(0, 0, 20);
    step();
    check_val("updated_eval_time", irrigation_time, 0);

    // Keypad pause mid-watering freezes the timer.
    run_eval(800, 500, 100, 700, 300, 400, 600, t, p, rise);
    wait_sig(2, 20, 200);
    config_busy = 1'b1;
    step();
    check_val("pause_pump", pump_on, 0);
    check_val("pause_wip", watering_in_progress, 1);
    check_val("pause_lcd", lcd_msg_sel, 4);
    for (int i = 0; i < 10 * TD; i++) begin
      step();
      check_val("pause_timer_hold", watering_timer, 20);
    end
    config_busy = 1'b0;
    step();
    check_val("resume_pump", pump_on, 1);
    check_val("resume_lcd", lcd_msg_sel, 2);
    finish_water(20, cyc);

    // Rain appearing during watering.
    run_eval(800, 500, 100, 700, 300, 400, 600, t, p, rise);
    repeat (5) step();
    rain_digital = 10'd700;
    step();
`ifdef IRRIG_RAIN_ABORT_EN
    check_val("abort_pump", pump_on, 0);
    check_val("abort_timer", watering_timer, 0);
    check_val("abort_lcd", lcd_msg_sel, 3);
    check_val("abort_rain", rain_present, 1);
    check_val("abort_wip", watering_in_progress, 0);
    rain_digital = 10'd100;
`else
    check_val("norain_abort_pump", pump_on, 1);
    check_val("norain_abort_flag", rain_present, 0);
    rain_digital = 10'd100;
    finish_water(t, p);
`endif

    // Randomized evaluations against the duration model.
    for (int k = 0; k < 12; k++) begin
      int s, tm, r, d, w, h, ry;
      s  = $urandom_range(0, 1023);
      d  = $urandom_range(400, 900);
      w  = $urandom_range(100, 399);
      tm = $urandom_range(0, 1023);
      h  = $urandom_range(200, 800);
      r  = $urandom_range(0, 1023);
      ry = $urandom_range(300, 1000);
      run_eval(s, tm, r, d, w, h, ry, t, p, rise);
      if (t > 0) finish_water(t, p);
    end

    // Asynchronous reset in the middle of watering.
    run_eval(800, 500, 100, 700, 300, 400, 600, t, p, rise);
    repeat (7) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midreset_pump", pump_on, 0);
    check_val("midreset_wip", watering_in_progress, 0);
    check_val("midreset_timer", watering_timer, 0);
    check_val("midreset_lcd", lcd_msg_sel, 0);
    check_val("midreset_irrig", irrigation_time, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
